// File: rtl/ccd_cds_sampler_if.sv
// -----------------------------------------------------------------------------
// ccd_cds_sampler_if
// Pixel output stream of the CCD correlated-double-sampling front end.
//   pix_data  : CDS pixel value (reset level minus signal level, floored at 0)
//   pix_valid : pix_data is valid; held until accepted
//   pix_last  : marks the last pixel of a line (qualified by pix_valid)
//   pix_ready : consumer accepts the pixel when high together with pix_valid
// Modports: master = pixel producer (the sampler), slave = pixel consumer.
// -----------------------------------------------------------------------------
interface ccd_cds_sampler_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_last;
    logic              pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        input  pix_last,
        output pix_ready
    );
endinterface

// File: rtl/ccd_cds_sampler.sv
// -----------------------------------------------------------------------------
// ccd_cds_sampler
// Correlated double sampler for a CCD readout chain. For every pixel it
// captures the sense-node reset level (SETTLE cycles after phi_r falls) and
// the signal level (SETTLE cycles after phi_l1 rises), and emits
// reset - signal (saturated at 0) on a valid/ready pixel stream.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   phi_l1, phi_p, phi_r : CCD clock phases, synchronous to clk
//   adc_data             : ADC sample, valid every cycle
//   pix_if (master)      : pix_data / pix_valid / pix_last / pix_ready
//   frame_start          : one-cycle pulse when a phi_p rise starts a line
//   overrun              : sticky flag, set when a finished pixel is dropped
// -----------------------------------------------------------------------------
module ccd_cds_sampler #(
    parameter int DATA_W          = 12,
    parameter int SETTLE          = 2,
    parameter int PIXELS_PER_LINE = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phi_l1,
    input  logic              phi_p,
    input  logic              phi_r,
    input  logic [DATA_W-1:0] adc_data,
    ccd_cds_sampler_if.master pix_if,
    output logic              frame_start,
    output logic              overrun
);

    localparam int IDX_W = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1;
    localparam logic [3:0]       CNT_LAST = 4'(SETTLE - 1);
    localparam logic [3:0]       CNT_ONE  = 4'd1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS_PER_LINE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RST = 3'd1,
        ST_SETTLE_R = 3'd2,
        ST_WAIT_SIG = 3'd3,
        ST_SETTLE_S = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              phi_l1_q, phi_p_q, phi_r_q;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] rst_lvl_q, rst_lvl_d;
    logic [DATA_W-1:0] sig_q, sig_d;
    // pend_q: both levels captured, result is formed and presented next cycle
    logic              pend_q, pend_d;
    logic              pend_last_q, pend_last_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              pix_last_q, pix_last_d;
    logic              frame_start_q, frame_start_d;
    logic              overrun_q, overrun_d;

    logic              l1_rise_s, p_rise_s, r_fall_s, cnt_last_s;
    logic [DATA_W-1:0] result_s;

    assign l1_rise_s  = phi_l1 & ~phi_l1_q;
    assign p_rise_s   = phi_p & ~phi_p_q;
    assign r_fall_s   = ~phi_r & phi_r_q;
    assign cnt_last_s = (cnt_q == CNT_LAST);

    // Signal above reset level means no charge (or noise): floor at zero.
    assign result_s = (sig_q > rst_lvl_q) ? {DATA_W{1'b0}} : (rst_lvl_q - sig_q);

    // Sequencer next-state: phi_p rise restarts the line from any state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        rst_lvl_d     = rst_lvl_q;
        sig_d         = sig_q;
        pend_d        = 1'b0;
        pend_last_d   = pend_last_q;
        frame_start_d = 1'b0;
        if (p_rise_s) begin
            state_d       = ST_WAIT_RST;
            cnt_d         = 4'd0;
            idx_d         = {IDX_W{1'b0}};
            frame_start_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT_RST: begin
                    if (r_fall_s) begin
                        state_d = ST_SETTLE_R;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT_RST;
                    end
                end
                ST_SETTLE_R: begin
                    if (cnt_last_s) begin
                        rst_lvl_d = adc_data;
                        state_d   = ST_WAIT_SIG;
                        cnt_d     = 4'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_SIG: begin
                    if (l1_rise_s) begin
                        state_d = ST_SETTLE_S;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT_SIG;
                    end
                end
                ST_SETTLE_S: begin
                    if (cnt_last_s) begin
                        sig_d       = adc_data;
                        pend_d      = 1'b1;
                        pend_last_d = (idx_q == IDX_LAST);
                        cnt_d       = 4'd0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_IDLE;
                            idx_d   = {IDX_W{1'b0}};
                        end else begin
                            state_d = ST_WAIT_RST;
                            idx_d   = idx_q + IDX_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    idx_d   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Output holding register: load new result, drop it on overrun, clear on accept.
    always_comb begin
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        overrun_d   = overrun_q;
        if (pend_q) begin
            if (pix_valid_q && !pix_if.pix_ready) begin
                overrun_d = 1'b1;
            end else begin
                pix_data_d  = result_s;
                pix_valid_d = 1'b1;
                pix_last_d  = pend_last_q;
            end
        end else if (pix_valid_q && pix_if.pix_ready) begin
            pix_valid_d = 1'b0;
        end else begin
            pix_valid_d = pix_valid_q;
        end
    end

    // State, edge-detect and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            phi_l1_q      <= 1'b0;
            phi_p_q       <= 1'b0;
            phi_r_q       <= 1'b0;
            cnt_q         <= 4'd0;
            idx_q         <= {IDX_W{1'b0}};
            rst_lvl_q     <= {DATA_W{1'b0}};
            sig_q         <= {DATA_W{1'b0}};
            pend_q        <= 1'b0;
            pend_last_q   <= 1'b0;
            pix_data_q    <= {DATA_W{1'b0}};
            pix_valid_q   <= 1'b0;
            pix_last_q    <= 1'b0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phi_l1_q      <= phi_l1;
            phi_p_q       <= phi_p;
            phi_r_q       <= phi_r;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rst_lvl_q     <= rst_lvl_d;
            sig_q         <= sig_d;
            pend_q        <= pend_d;
            pend_last_q   <= pend_last_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_last_q    <= pix_last_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
        end
    end

    assign pix_if.pix_data  = pix_data_q;
    assign pix_if.pix_valid = pix_valid_q;
    assign pix_if.pix_last  = pix_last_q;
    assign frame_start      = frame_start_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_ccd_cds_sampler.sv
// -----------------------------------------------------------------------------
// tb_ccd_cds_sampler
// Directed bench for ccd_cds_sampler (DATA_W=12, SETTLE=2, 64 pixels/line).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_ccd_cds_sampler;

    logic        clk;
    logic        rst_n;
    logic        phi_l1;
    logic        phi_p;
    logic        phi_r;
    logic [11:0] adc_data;
    logic        frame_start;
    logic        overrun;

    int n_checks;
    int n_fail;

    ccd_cds_sampler_if #(.DATA_W(12)) pif ();

    ccd_cds_sampler #(
        .DATA_W          (12),
        .SETTLE          (2),
        .PIXELS_PER_LINE (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phi_l1      (phi_l1),
        .phi_p       (phi_p),
        .phi_r       (phi_r),
        .adc_data    (adc_data),
        .pix_if      (pif.master),
        .frame_start (frame_start),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // phi_p pulse; frame_start must pulse for exactly one cycle.
    task automatic start_line();
        phi_p = 1'b1;
        tick();
        check_eq("frame_start_pulse", 32'(frame_start), 32'd1);
        phi_p = 1'b0;
        tick();
        check_eq("frame_start_clear", 32'(frame_start), 32'd0);
    endtask

    // Drives one pixel; returns right after the edge that captures the signal
    // level, so the result appears after the next tick.
    task automatic run_pixel(input logic [11:0] r_lvl, input logic [11:0] s_lvl);
        phi_r    = 1'b1;
        adc_data = r_lvl;
        tick();
        phi_r = 1'b0;
        tick();
        tick();
        tick();
        phi_l1   = 1'b1;
        adc_data = s_lvl;
        tick();
        phi_l1 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        phi_l1       = 1'b0;
        phi_p        = 1'b0;
        phi_r        = 1'b0;
        adc_data     = 12'h000;
        pif.pix_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_valid", 32'(pif.pix_valid), 32'd0);
        check_eq("rst_data", 32'(pif.pix_data), 32'd0);
        check_eq("rst_last", 32'(pif.pix_last), 32'd0);
        check_eq("rst_frame_start", 32'(frame_start), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic CDS: 0x800 - 0x300, latency SETTLE+1 after phi_l1 rise edge
        start_line();
        run_pixel(12'h800, 12'h300);
        check_eq("lat_not_early", 32'(pif.pix_valid), 32'd0);
        tick();
        check_eq("basic_valid", 32'(pif.pix_valid), 32'd1);
        check_eq("basic_data", 32'(pif.pix_data), 32'h500);
        check_eq("basic_last", 32'(pif.pix_last), 32'd0);
        tick();
        check_eq("basic_one_beat", 32'(pif.pix_valid), 32'd0);

        // Saturation and range boundaries
        run_pixel(12'h800, 12'h900);
        tick();
        check_eq("sat_valid", 32'(pif.pix_valid), 32'd1);
        check_eq("sat_data", 32'(pif.pix_data), 32'h000);
        run_pixel(12'h555, 12'h555);
        tick();
        check_eq("equal_data", 32'(pif.pix_data), 32'h000);
        run_pixel(12'hFFF, 12'h000);
        tick();
        check_eq("full_scale_data", 32'(pif.pix_data), 32'hFFF);

        // Abort in SETTLE_S: no pixel, frame_start, line restarts at index 0
        phi_r    = 1'b1;
        adc_data = 12'h800;
        tick();
        phi_r = 1'b0;
        repeat (3) tick();
        phi_l1   = 1'b1;
        adc_data = 12'h100;
        tick();
        phi_l1 = 1'b0;
        phi_p  = 1'b1;
        tick();
        check_eq("abort_frame_start", 32'(frame_start), 32'd1);
        phi_p = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("abort_no_pixel", 32'(pif.pix_valid), 32'd0);
        end

        // Full line: r = 0x400+i, s = 3i -> 0x400-2i; last only on pixel 63
        for (int i = 0; i < 64; i++) begin
            run_pixel(12'(12'h400 + i), 12'(3 * i));
            tick();
            check_eq("line_valid", 32'(pif.pix_valid), 32'd1);
            check_eq("line_data", 32'(pif.pix_data), 32'(12'h400 - 2 * i));
            check_eq("line_last", 32'(pif.pix_last), (i == 63) ? 32'd1 : 32'd0);
        end
        tick();
        check_eq("line_end_drop", 32'(pif.pix_valid), 32'd0);
        // Back in IDLE: phase edges without phi_p produce nothing
        run_pixel(12'h800, 12'h100);
        tick();
        check_eq("idle_ignores", 32'(pif.pix_valid), 32'd0);
        tick();
        check_eq("idle_ignores_2", 32'(pif.pix_valid), 32'd0);

        // Accept and new result in the same cycle: loads, no overrun
        start_line();
        pif.pix_ready = 1'b0;
        run_pixel(12'h300, 12'h100);
        tick();
        check_eq("hold_valid", 32'(pif.pix_valid), 32'd1);
        check_eq("hold_data", 32'(pif.pix_data), 32'h200);
        run_pixel(12'h400, 12'h100);
        check_eq("hold_kept", 32'(pif.pix_data), 32'h200);
        pif.pix_ready = 1'b1;
        tick();
        check_eq("swap_valid", 32'(pif.pix_valid), 32'd1);
        check_eq("swap_data", 32'(pif.pix_data), 32'h300);
        check_eq("swap_no_overrun", 32'(overrun), 32'd0);
        tick();
        check_eq("swap_drop", 32'(pif.pix_valid), 32'd0);

        // Stall across two pixels: second dropped, overrun sticky
        pif.pix_ready = 1'b0;
        run_pixel(12'h700, 12'h200);
        tick();
        check_eq("ovr_first_data", 32'(pif.pix_data), 32'h500);
        check_eq("ovr_not_yet", 32'(overrun), 32'd0);
        run_pixel(12'h650, 12'h100);
        tick();
        check_eq("ovr_held_valid", 32'(pif.pix_valid), 32'd1);
        check_eq("ovr_held_data", 32'(pif.pix_data), 32'h500);
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        pif.pix_ready = 1'b1;
        tick();
        check_eq("ovr_delivered_once", 32'(pif.pix_valid), 32'd0);
        repeat (3) tick();
        check_eq("ovr_sticky", 32'(overrun), 32'd1);
        check_eq("ovr_no_second", 32'(pif.pix_valid), 32'd0);

        // Asynchronous reset mid-SETTLE_R
        pif.pix_ready = 1'b0;
        run_pixel(12'h900, 12'h100);
        tick();
        check_eq("pre_rst_data", 32'(pif.pix_data), 32'h800);
        phi_r    = 1'b1;
        adc_data = 12'h444;
        tick();
        phi_r = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(pif.pix_valid), 32'd0);
        check_eq("arst_data", 32'(pif.pix_data), 32'd0);
        check_eq("arst_last", 32'(pif.pix_last), 32'd0);
        check_eq("arst_overrun", 32'(overrun), 32'd0);
        check_eq("arst_frame_start", 32'(frame_start), 32'd0);
        tick();
        rst_n = 1'b1;
        pif.pix_ready = 1'b1;
        run_pixel(12'h800, 12'h100);
        tick();
        check_eq("post_rst_no_pixel", 32'(pif.pix_valid), 32'd0);
        tick();
        check_eq("post_rst_no_pixel_2", 32'(pif.pix_valid), 32'd0);

        // phi_p held high through reset: first cycle after release is a rise
        rst_n = 1'b0;
        phi_p = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("phi_p_high_rst_fs", 32'(frame_start), 32'd1);
        phi_p = 1'b0;
        tick();
        run_pixel(12'h123, 12'h023);
        tick();
        check_eq("after_rst_valid", 32'(pif.pix_valid), 32'd1);
        check_eq("after_rst_data", 32'(pif.pix_data), 32'h100);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
